// File: rtl/abus_master_queue.sv
// Command FIFO and one-at-a-time issue sequencer in front of abus_master.
// A watchdog aborts transactions whose done never arrives so the requester is never stuck.
module abus_master_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                              abus_clk,
  input  logic                              abus_rstb,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [ADDR_WIDTH-1:0]             cmd_address,
  input  logic [DATA_WIDTH-1:0]             cmd_wdata,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]   cmd_strb,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]   cmd_keep,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              write,
  output logic                              read,
  output logic                              abort,
  output logic [ADDR_WIDTH-1:0]             address,
  output logic [DATA_WIDTH-1:0]             wdata,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   strb,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   keep,
  input  logic [DATA_WIDTH-1:0]             rdata,
  input  logic                              new_rdata,
  input  logic                              done,
  input  logic                              err,
  output logic                              busy
);
  localparam int SW = $clog2(DATA_WIDTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_WAIT  = 2'd1,
    Q_ABORT = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic                  r_mem_write [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_wdata [DEPTH];
  logic [SW-1:0]         r_mem_strb  [DEPTH];
  logic [SW-1:0]         r_mem_keep  [DEPTH];
  logic [IW-1:0]         w_widx, w_ridx;
  logic                  w_full, w_empty, w_push, w_pop;
  logic                  w_load, w_load_err, w_abort_nxt;
  logic [DATA_WIDTH-1:0] w_load_rdata;
  logic [7:0]            r_wdog, w_wdog_nxt;
  logic                  r_write, r_read, r_abort, r_op_write, r_busy;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb, r_keep;
  logic                  r_rsp_valid, r_rsp_write, r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  assign w_widx     = r_wptr[IW-1:0];
  assign w_ridx     = r_rptr[IW-1:0];
  assign w_full     = (r_wptr[PW-1] != r_rptr[PW-1]) && (w_widx == w_ridx);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_push     = cmd_valid && !w_full;
  assign w_wptr_nxt = r_wptr + {{IW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{IW{1'b0}}, w_pop};

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign write     = r_write;
  assign read      = r_read;
  assign abort     = r_abort;
  assign address   = r_address;
  assign wdata     = r_wdata;
  assign strb      = r_strb;
  assign keep      = r_keep;
  assign busy      = r_busy;

  // Command storage; contents are only meaningful between the pointers.
  always_ff @(posedge abus_clk) begin
    if (w_push) begin
      r_mem_write[w_widx] <= cmd_write;
      r_mem_addr[w_widx]  <= cmd_address;
      r_mem_wdata[w_widx] <= cmd_wdata;
      r_mem_strb[w_widx]  <= cmd_strb;
      r_mem_keep[w_widx]  <= cmd_keep;
    end
  end

  // FIFO pointers, state and watchdog registers.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_state <= Q_IDLE;
      r_wdog  <= 8'd0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  // Issue / wait / abort sequencing; done takes priority over an expiring watchdog.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_err   = 1'b0;
    w_load_rdata = {DATA_WIDTH{1'b0}};
    w_abort_nxt  = 1'b0;
    w_wdog_nxt   = 8'd0;
    case (r_state)
      Q_IDLE: begin
        if (!w_empty && (!r_rsp_valid || rsp_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = Q_WAIT;
        end else begin
          w_state_nxt = Q_IDLE;
        end
      end
      Q_WAIT: begin
        if (done) begin
          w_load       = 1'b1;
          w_load_err   = err;
          w_load_rdata = new_rdata ? rdata : {DATA_WIDTH{1'b0}};
          w_state_nxt  = Q_IDLE;
        end else if (r_wdog == TO_LAST) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = Q_ABORT;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
        end
      end
      Q_ABORT: begin
        if (done || (r_wdog == TO_LAST)) begin
          w_load      = 1'b1;
          w_load_err  = 1'b1;
          w_state_nxt = Q_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
        end
      end
      default: begin
        w_state_nxt = Q_IDLE;
      end
    endcase
  end

  // Order pulses, held operands, response slot and busy flag.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_abort     <= 1'b0;
      r_op_write  <= 1'b0;
      r_address   <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_strb      <= {SW{1'b0}};
      r_keep      <= {SW{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_write <= w_pop && r_mem_write[w_ridx];
      r_read  <= w_pop && !r_mem_write[w_ridx];
      r_abort <= w_abort_nxt;
      if (w_pop) begin
        r_op_write <= r_mem_write[w_ridx];
        r_address  <= r_mem_addr[w_ridx];
        r_wdata    <= r_mem_write[w_ridx] ? r_mem_wdata[w_ridx] : {DATA_WIDTH{1'b0}};
        r_strb     <= r_mem_strb[w_ridx];
        r_keep     <= r_mem_keep[w_ridx];
      end else if (w_state_nxt == Q_IDLE) begin
        r_op_write <= 1'b0;
        r_address  <= {ADDR_WIDTH{1'b0}};
        r_wdata    <= {DATA_WIDTH{1'b0}};
        r_strb     <= {SW{1'b0}};
        r_keep     <= {SW{1'b0}};
      end
      if (w_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_write <= r_op_write;
        r_rsp_rdata <= w_load_rdata;
        r_rsp_err   <= w_load_err;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      r_busy <= (w_state_nxt != Q_IDLE) || (w_wptr_nxt != w_rptr_nxt);
    end
  end
endmodule

// File: tb/tb_abus_master_queue.sv
// Directed self-checking bench for abus_master_queue; the bench plays requester and master.
module tb_abus_master_queue;
  logic        abus_clk, abus_rstb;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_address, cmd_wdata;
  logic [4:0]  cmd_strb, cmd_keep;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [15:0] rsp_rdata;
  logic        write, read, abort;
  logic [15:0] address, wdata, rdata;
  logic [4:0]  strb, keep;
  logic        new_rdata, done, err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  abus_master_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .TIMEOUT(15)) dut (
    .abus_clk(abus_clk), .abus_rstb(abus_rstb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_keep(cmd_keep),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .write(write), .read(read), .abort(abort),
    .address(address), .wdata(wdata), .strb(strb), .keep(keep),
    .rdata(rdata), .new_rdata(new_rdata), .done(done), .err(err), .busy(busy)
  );

  initial abus_clk = 1'b0;
  always #5 abus_clk = ~abus_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge abus_clk);
    @(negedge abus_clk);
  endtask

  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_wdata = d;
    cmd_strb = 5'd2; cmd_keep = 5'd2;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    abus_rstb = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 16'h0; cmd_wdata = 16'h0;
    cmd_strb = 5'd0; cmd_keep = 5'd0; rsp_ready = 1'b0;
    rdata = 16'h0; new_rdata = 1'b0; done = 1'b0; err = 1'b0;
    repeat (3) @(negedge abus_clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_tests++; if ({write, read, abort} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {write, read, abort}); end
    n_tests++; if ({rsp_valid, busy, rsp_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {rsp_valid, busy, rsp_err}); end
    n_tests++; if (address !== 16'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0000", address); end
    abus_rstb = 1'b1;
    step();
    n_tests++; if ({busy, write, read} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got %b want 000", {busy, write, read}); end
  endtask

  task automatic test_single_write();
    push(1'b1, 16'h0012, 16'hBEEF);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy); end
    step();
    n_tests++; if ({write, read, abort} !== 3'b100) begin n_fail++; $display("FAIL wr_pulse: got %b want 100", {write, read, abort}); end
    n_tests++; if ({address, wdata} !== {16'h0012, 16'hBEEF}) begin n_fail++; $display("FAIL wr_operands: got %h want 0012beef", {address, wdata}); end
    n_tests++; if (strb !== 5'd2) begin n_fail++; $display("FAIL wr_strb: got %0d want 2", strb); end
    step();
    n_tests++; if (write !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width: got %b want 0", write); end
    step();
    n_tests++; if ({address, wdata} !== {16'h0012, 16'hBEEF}) begin n_fail++; $display("FAIL wr_hold: got %h want 0012beef", {address, wdata}); end
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin n_fail++; $display("FAIL wr_rsp_flags: got %b want 110", {rsp_valid, rsp_write, rsp_err}); end
    n_tests++; if (rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h want 0000", rsp_rdata); end
    n_tests++; if ({address, busy} !== 17'h0) begin n_fail++; $display("FAIL wr_idle_zero: got %h want 0", {address, busy}); end
    drain();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read();
    push(1'b0, 16'h0100, 16'h1111);
    step();
    n_tests++; if ({write, read} !== 2'b01) begin n_fail++; $display("FAIL rd_pulse: got %b want 01", {write, read}); end
    n_tests++; if ({address, wdata} !== {16'h0100, 16'h0000}) begin n_fail++; $display("FAIL rd_operands: got %h want 01000000", {address, wdata}); end
    done = 1'b1; new_rdata = 1'b1; rdata = 16'h5A5A;
    step();
    done = 1'b0; new_rdata = 1'b0; rdata = 16'h0;
    n_tests++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100) begin n_fail++; $display("FAIL rd_rsp_flags: got %b want 100", {rsp_valid, rsp_write, rsp_err}); end
    n_tests++; if (rsp_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 5a5a", rsp_rdata); end
    drain();
  endtask

  task automatic test_backpressure();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'h0200; cmd_wdata = 16'h0002;
    step();
    cmd_address = 16'h0300; cmd_wdata = 16'h0003;
    step();
    cmd_valid = 1'b0;
    n_tests++; if ({write, address} !== {1'b1, 16'h0200}) begin n_fail++; $display("FAIL bp_first_issue: got %h want 10200", {write, address}); end
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (3) step();
    n_tests++; if ({rsp_valid, write, read, busy} !== 4'b1001) begin n_fail++; $display("FAIL bp_held: got %b want 1001", {rsp_valid, write, read, busy}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_tests++; if ({write, rsp_valid, address} !== {2'b10, 16'h0300}) begin n_fail++; $display("FAIL bp_second_issue: got %h want 20300", {write, rsp_valid, address}); end
    done = 1'b1;
    step();
    done = 1'b0;
    drain();
  endtask

  task automatic test_full();
    logic [15:0] exp_rd [6];
    int n_rsp, cyc;
    logic prev_pulse, viol, drop_valid;
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'hA5B5; exp_rd[2] = 16'hA585;
    exp_rd[3] = 16'hA595; exp_rd[4] = 16'hA5E5; exp_rd[5] = 16'hA5F5;
    push(1'b1, 16'h0001, 16'h0001);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'((i + 1) * 16);
      step();
      if (i == 2) begin
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_3: got %b want 1", cmd_ready); end
      end
    end
    cmd_address = 16'h0050;
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_4: got %b want 0", cmd_ready); end
    repeat (3) step();
    n_tests++; if ({cmd_ready, read, write, busy} !== 4'b0001) begin n_fail++; $display("FAIL full_stall: got %b want 0001", {cmd_ready, read, write, busy}); end
    rsp_ready = 1'b1;
    n_rsp = 0; cyc = 0; prev_pulse = 1'b0; viol = 1'b0; drop_valid = 1'b0;
    while (cyc < 200 && n_rsp < 6) begin
      if (drop_valid) cmd_valid = 1'b0;
      done = 1'b0; new_rdata = 1'b0; rdata = 16'h0;
      if (rsp_valid) begin
        n_tests++; if (rsp_rdata !== exp_rd[n_rsp]) begin n_fail++; $display("FAIL full_order_%0d: got %h want %h", n_rsp, rsp_rdata, exp_rd[n_rsp]); end
        n_rsp++;
      end
      if ((write || read || abort) && prev_pulse) viol = 1'b1;
      if ((32'(write) + 32'(read) + 32'(abort)) > 32'd1) viol = 1'b1;
      prev_pulse = write || read || abort;
      if (write || read) begin
        done = 1'b1; new_rdata = read; rdata = address ^ 16'hA5A5;
      end
      if (cmd_valid && cmd_ready) drop_valid = 1'b1;
      step();
      cyc++;
    end
    cmd_valid = 1'b0; done = 1'b0; new_rdata = 1'b0; rdata = 16'h0; rsp_ready = 1'b0;
    n_tests++; if (n_rsp != 6) begin n_fail++; $display("FAIL full_rsp_count: got %0d want 6", n_rsp); end
    n_tests++; if (viol !== 1'b0) begin n_fail++; $display("FAIL full_pulse_spacing: got %b want 0", viol); end
    n_tests++; if ({busy, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL full_end_idle: got %b want 01", {busy, cmd_ready}); end
  endtask

  task automatic test_timeout();
    int cyc;
    push(1'b1, 16'h0400, 16'h0004);
    step();
    n_tests++; if (write !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b want 1", write); end
    cyc = 0;
    while (cyc < 40 && abort !== 1'b1) begin
      step();
      cyc++;
    end
    n_tests++; if (cyc != 15) begin n_fail++; $display("FAIL to_abort_cycle: got %0d want 15", cyc); end
    step();
    n_tests++; if ({abort, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL to_abort_width: got %b want 00", {abort, rsp_valid}); end
    done = 1'b1; new_rdata = 1'b1; rdata = 16'hFFFF;
    step();
    done = 1'b0; new_rdata = 1'b0; rdata = 16'h0;
    n_tests++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b111) begin n_fail++; $display("FAIL to_rsp_flags: got %b want 111", {rsp_valid, rsp_err, rsp_write}); end
    n_tests++; if (rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL to_rsp_rdata: got %h want 0000", rsp_rdata); end
    drain();
    push(1'b1, 16'h0500, 16'h0005);
    step();
    repeat (14) step();
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++; if ({abort, rsp_valid, rsp_err} !== 3'b010) begin n_fail++; $display("FAIL to_done_wins: got %b want 010", {abort, rsp_valid, rsp_err}); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'(16'h0600 + i); cmd_wdata = 16'hCAFE;
      step();
    end
    cmd_valid = 1'b0;
    n_tests++; if ({busy, address} !== {1'b1, 16'h0600}) begin n_fail++; $display("FAIL rm_pre: got %h want 10600", {busy, address}); end
    #2 abus_rstb = 1'b0;
    #1;
    n_tests++; if ({address, wdata} !== 32'h0) begin n_fail++; $display("FAIL rm_operands: got %h want 0", {address, wdata}); end
    n_tests++; if ({write, read, abort, rsp_valid, busy, cmd_ready} !== 6'b000001) begin n_fail++; $display("FAIL rm_flags: got %b want 000001", {write, read, abort, rsp_valid, busy, cmd_ready}); end
    step();
    step();
    abus_rstb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (write || read || abort || busy || rsp_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: got %b want 0", seen); end
    push(1'b0, 16'h0777, 16'h0000);
    step();
    n_tests++; if ({read, address} !== {1'b1, 16'h0777}) begin n_fail++; $display("FAIL rm_new_issue: got %h want 10777", {read, address}); end
    done = 1'b1; new_rdata = 1'b1; rdata = 16'h1234;
    step();
    done = 1'b0; new_rdata = 1'b0; rdata = 16'h0;
    n_tests++; if (rsp_rdata !== 16'h1234) begin n_fail++; $display("FAIL rm_new_rsp: got %h want 1234", rsp_rdata); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_backpressure();
    test_full();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
